// File: rtl/clock_gating_ctrl.sv
// Idle-driven clock-gate enable controller with a wake handshake.
// Optional gated-cycle counter: define CLOCK_GATING_STATS_EN.
module clock_gating_ctrl #(
  parameter int CNT_W       = 8,
  parameter int WAKE_CYCLES = 2,
  parameter int STAT_W      = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cfg_en_i,
  input  logic [CNT_W-1:0]  idle_thr_i,
  input  logic              busy_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  output logic              en_o,
  output logic              gated_o,
  output logic [STAT_W-1:0] gated_cycles_o
);

  typedef enum logic [1:0] {
    ACTIVE,
    GATED,
    WAKE
  } state_e;

  localparam int WK_W =
    (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
  localparam logic [WK_W-1:0] WK_LD =
    WK_W'((WAKE_CYCLES > 0) ? WAKE_CYCLES - 1 : 0);

  state_e          state_q;
  logic [CNT_W-1:0] idle_q;
  logic [WK_W-1:0] wk_q;
  logic            en_q;
  logic            ready_q;
  logic            gated_q;

  logic             act;
  logic [CNT_W-1:0] thr_m1;
  logic             thr_hit;

  assign act     = busy_i | req_valid_i | ~cfg_en_i;
  assign thr_m1  = idle_thr_i - CNT_W'(1);
  // >= so a threshold lowered mid-count still gates
  assign thr_hit = (idle_q >= thr_m1);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ACTIVE;
      idle_q  <= '0;
      wk_q    <= '0;
      en_q    <= 1'b1;
      ready_q <= 1'b1;
      gated_q <= 1'b0;
    end else begin
      unique case (state_q)
        ACTIVE: begin
          if (act || (idle_thr_i == '0)) begin
            idle_q <= '0;
          end else if (thr_hit) begin
            state_q <= GATED;
            idle_q  <= '0;
            en_q    <= 1'b0;
            ready_q <= 1'b0;
            gated_q <= 1'b1;
          end else if (idle_q != '1) begin
            idle_q <= idle_q + CNT_W'(1);
          end
        end
        GATED: begin
          idle_q <= '0;
          if (act) begin
            en_q    <= 1'b1;
            gated_q <= 1'b0;
            if (WAKE_CYCLES == 0) begin
              state_q <= ACTIVE;
              ready_q <= 1'b1;
            end else begin
              state_q <= WAKE;
              wk_q    <= WK_LD;
            end
          end
        end
        WAKE: begin
          // settle time runs to completion whatever the inputs do
          idle_q <= '0;
          if (wk_q == '0) begin
            state_q <= ACTIVE;
            ready_q <= 1'b1;
          end else begin
            wk_q <= wk_q - WK_W'(1);
          end
        end
        default: begin
          state_q <= ACTIVE;
          idle_q  <= '0;
          en_q    <= 1'b1;
          ready_q <= 1'b1;
          gated_q <= 1'b0;
        end
      endcase
    end
  end

  assign en_o        = en_q;
  assign req_ready_o = ready_q;
  assign gated_o     = gated_q;

`ifdef CLOCK_GATING_STATS_EN
  logic [STAT_W-1:0] stat_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      stat_q <= '0;
    end else if (!en_q) begin
      stat_q <= stat_q + STAT_W'(1);
    end
  end

  assign gated_cycles_o = stat_q;
`else
  assign gated_cycles_o = '0;
`endif

endmodule

// File: tb/tb_clock_gating_ctrl.sv
// Random + directed bench for clock_gating_ctrl.
// Reference model tracks idle run length and wake deadline.
module tb_clock_gating_ctrl;

  localparam int CNT_W       = 8;
  localparam int WAKE_CYCLES = 2;
  localparam int STAT_W      = 32;
`ifdef CLOCK_GATING_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cfg_en = 1'b1;
  logic             busy = 1'b0;
  logic             req = 1'b0;
  logic [CNT_W-1:0] thr = 8'd4;
  logic             ready;
  logic             en;
  logic             gated;
  logic [STAT_W-1:0] gcyc;

  always #5 clk = ~clk;

  clock_gating_ctrl #(
    .CNT_W(CNT_W),
    .WAKE_CYCLES(WAKE_CYCLES),
    .STAT_W(STAT_W)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .cfg_en_i(cfg_en),
    .idle_thr_i(thr),
    .busy_i(busy),
    .req_valid_i(req),
    .req_ready_o(ready),
    .en_o(en),
    .gated_o(gated),
    .gated_cycles_o(gcyc)
  );

  int ncmp = 0;
  int nfail = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s at %0t: got %0h want %0h",
               nm, $time, act, exp);
    end
  endtask

  // reference model: domain is gated, waking, or running
  bit          m_en = 1'b1;
  bit          m_ready = 1'b1;
  bit          m_gated = 1'b0;
  bit          m_waking = 1'b0;
  int          idle_run = 0;
  int          wake_left = 0;
  longint unsigned m_stat = 0;

  always @(posedge clk) begin
    bit a;
    a = busy | req | ~cfg_en;
    if (!rst_n) begin
      m_en = 1'b1; m_ready = 1'b1; m_gated = 1'b0;
      m_waking = 1'b0; idle_run = 0; m_stat = 0;
    end else begin
      if (!m_en) m_stat++;
      if (m_gated) begin
        if (a) begin
          m_gated = 1'b0;
          m_en = 1'b1;
          if (WAKE_CYCLES == 0) m_ready = 1'b1;
          else begin
            m_waking = 1'b1;
            wake_left = WAKE_CYCLES;
          end
        end
      end else if (m_waking) begin
        wake_left--;
        if (wake_left == 0) begin
          m_waking = 1'b0;
          m_ready = 1'b1;
        end
      end else if (a || thr == 0) begin
        idle_run = 0;
      end else begin
        idle_run++;
        if (idle_run >= int'(thr)) begin
          m_gated = 1'b1; m_en = 1'b0; m_ready = 1'b0;
          idle_run = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("en_o", 64'(en), 64'(m_en));
      chk("req_ready_o", 64'(ready), 64'(m_ready));
      chk("gated_o", 64'(gated), 64'(m_gated));
      chk("gated_cycles_o", 64'(gcyc),
          STATS ? 64'(m_stat[STAT_W-1:0]) : 64'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tick(); tick();
    chk_on = 1'b1;
    rst_n = 1'b1;
    chk("rst_en", 64'(en), 64'd1);
    chk("rst_ready", 64'(ready), 64'd1);
    chk("rst_gated", 64'(gated), 64'd0);
    chk("rst_stat", 64'(gcyc), 64'd0);

    repeat (3) tick();
    chk("pre_gate_en", 64'(en), 64'd1);
    tick();
    chk("gate_en", 64'(en), 64'd0);
    chk("gate_gated", 64'(gated), 64'd1);
    repeat (5) tick();
    chk("stay_gated", 64'(gated), 64'd1);

    req = 1'b1;
    tick();
    chk("wake_en", 64'(en), 64'd1);
    chk("wake_rdy0", 64'(ready), 64'd0);
    tick();
    chk("wake_rdy1", 64'(ready), 64'd0);
    tick();
    chk("wake_rdy2", 64'(ready), 64'd1);
    req = 1'b0;

    repeat (3) tick();
    busy = 1'b1;
    tick();
    chk("thr_busy_en", 64'(en), 64'd1);
    busy = 1'b0;
    repeat (3) tick();
    chk("restart_en", 64'(en), 64'd1);
    tick();
    chk("restart_gate", 64'(en), 64'd0);

    rst_n = 1'b0;
    tick();
    chk("rstg_en", 64'(en), 64'd1);
    chk("rstg_rdy", 64'(ready), 64'd1);
    chk("rstg_gated", 64'(gated), 64'd0);
    rst_n = 1'b1;
    repeat (3) tick();
    chk("rstg_cnt", 64'(en), 64'd1);
    tick();
    chk("rstg_regate", 64'(en), 64'd0);

    req = 1'b1;
    tick();
    chk("rstw_wake", 64'(ready), 64'd0);
    rst_n = 1'b0;
    req = 1'b0;
    tick();
    chk("rstw_rdy", 64'(ready), 64'd1);
    chk("rstw_en", 64'(en), 64'd1);
    rst_n = 1'b1;

    thr = 8'd0;
    repeat (40) tick();
    chk("thr0_en", 64'(en), 64'd1);

    thr = 8'd1;
    cfg_en = 1'b0;
    repeat (20) tick();
    chk("cfg0_en", 64'(en), 64'd1);
    cfg_en = 1'b1;
    tick();
    chk("thr1_gate", 64'(en), 64'd0);
    cfg_en = 1'b0;
    tick();
    chk("cfg_wake_en", 64'(en), 64'd1);
    chk("cfg_wake_rdy", 64'(ready), 64'd0);
    cfg_en = 1'b1;
    tick(); tick();
    chk("cfg_wake_done", 64'(ready), 64'd1);
    cfg_en = 1'b0;
    repeat (10) tick();
    chk("cfg0_hold", 64'(en), 64'd1);
    cfg_en = 1'b1;

    rst_n = 1'b0;
    thr = 8'd2;
    tick();
    rst_n = 1'b1;
    tick(); tick();
    chk("stat_gate", 64'(gated), 64'd1);
    repeat (10) tick();
    chk("stat_10", 64'(gcyc), STATS ? 64'd10 : 64'd0);
    req = 1'b1;
    repeat (3) tick();
    req = 1'b0;

    for (int i = 0; i < 4000; i++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 49) == 0)
        thr = CNT_W'($urandom_range(0, 6));
      busy = ($urandom_range(0, 9) == 0);
      cfg_en = ($urandom_range(0, 39) != 0);
      if (!req) req = ($urandom_range(0, 19) == 0);
      else if (ready) req = ($urandom_range(0, 1) == 0);
      else if ($urandom_range(0, 15) == 0) req = 1'b0;
      tick();
    end

    @(posedge clk);
    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nfail);
    $finish;
  end

endmodule
